// File: rtl/rtc_ctrl_pkg.sv
// Shared definitions for the RTC main sequencer: state encodings, defaults
// and the grant-index width helper.
package rtc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT      = 3'b000,
        ST_WHILE     = 3'b001,
        ST_SOLICITUD = 3'b010,
        ST_CONTROL   = 3'b011,
        ST_ABORT     = 3'b100
    } state_e;

    localparam int DEF_N_CH      = 2;
    localparam int DEF_TO_CYCLES = 1024;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rtc_main_ctrl_arbiter.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping around the channel count.
module rtc_rr_arbiter
    import rtc_ctrl_pkg::*;
#(
    parameter  int N_CH = DEF_N_CH,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] gnt_idx,
    output logic            gnt_vld
);

    logic [CH_W-1:0] cand_s;
    logic            hit_s;

    // Walk the channels starting at ptr and keep the first requester found.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cand_s  = CH_W'((int'(ptr) + i) % N_CH);
            hit_s   = !gnt_vld && req[cand_s];
            gnt_idx = hit_s ? cand_s : gnt_idx;
            gnt_vld = gnt_vld | hit_s;
        end
    end

endmodule

// File: rtl/rtc_main_ctrl.sv
// RTC main sequencer: one-time init, polling loop, round-robin service of
// user-control channels between polls.
// Optional per-phase watchdog (INIT/CONTROL) with ABORT state and wdt_err
// pulse is built when RTC_CTRL_WDT_EN is defined.
module rtc_main_ctrl
    import rtc_ctrl_pkg::*;
#(
    parameter  int N_CH      = DEF_N_CH,
    parameter  int TO_CYCLES = DEF_TO_CYCLES,
    localparam int CH_W      = ch_width(N_CH)
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            finint,
    input  logic            finwt,
    input  logic            finct,
    input  logic [N_CH-1:0] usuario,
    output logic            iniciar,
    output logic            whileT,
    output logic [N_CH-1:0] CrontUs,
    output logic [CH_W-1:0] grant_id,
    output logic [2:0]      State,
    output logic            wdt_err
);

    state_e          state_q, state_d;
    logic [CH_W-1:0] grant_id_q, grant_id_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            iniciar_q, iniciar_d;
    logic            whilet_q, whilet_d;
    logic [N_CH-1:0] crontus_q, crontus_d;
    logic            wdt_err_q, wdt_err_d;
    logic [CH_W-1:0] arb_idx_s;
    logic            arb_vld_s;
    logic            timeout_s;

    rtc_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (usuario),
        .ptr     (rr_ptr_q),
        .gnt_idx (arb_idx_s),
        .gnt_vld (arb_vld_s)
    );

`ifdef RTC_CTRL_WDT_EN
    localparam int              TO_W       = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0] WDT_LIMIT  = TO_W'(TO_CYCLES - 1);
    localparam logic            WDT_ERR_ON = 1'b1;

    logic [TO_W-1:0] wdt_cnt_q, wdt_cnt_d;

    assign timeout_s = ((state_q == ST_INIT) || (state_q == ST_CONTROL)) &&
                       (wdt_cnt_q == WDT_LIMIT);

    // Watchdog count: restart on any state change, count up (saturating) in guarded phases.
    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        if (state_d != state_q) begin
            wdt_cnt_d = '0;
        end else if (((state_q == ST_INIT) || (state_q == ST_CONTROL)) &&
                     (wdt_cnt_q != WDT_LIMIT)) begin
            wdt_cnt_d = wdt_cnt_q + TO_W'(1);
        end else begin
            wdt_cnt_d = wdt_cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wdt_cnt_q <= '0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
        end
    end
`else
    localparam logic WDT_ERR_ON = 1'b0;

    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a phase's own fin input beats a simultaneous timeout.
    always_comb begin
        state_d = ST_INIT;
        case (state_q)
            ST_INIT: begin
                if (finint)         state_d = ST_WHILE;
                else if (timeout_s) state_d = ST_ABORT;
                else                state_d = ST_INIT;
            end
            ST_WHILE:     state_d = finwt ? ST_SOLICITUD : ST_WHILE;
            ST_SOLICITUD: state_d = arb_vld_s ? ST_CONTROL : ST_WHILE;
            ST_CONTROL: begin
                if (finct)          state_d = ST_WHILE;
                else if (timeout_s) state_d = ST_ABORT;
                else                state_d = ST_CONTROL;
            end
            ST_ABORT:     state_d = ST_INIT;
            default:      state_d = ST_INIT;
        endcase
    end

    // Grant latch on CONTROL entry; pointer moves past the grant on CONTROL exit.
    always_comb begin
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        if ((state_q == ST_SOLICITUD) && (state_d == ST_CONTROL)) begin
            grant_id_d = arb_idx_s;
        end else begin
            grant_id_d = grant_id_q;
        end
        if ((state_q == ST_CONTROL) && (state_d != ST_CONTROL)) begin
            rr_ptr_d = (int'(grant_id_q) >= N_CH - 1) ? '0 : grant_id_q + CH_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Output decode from the next state so the registered outputs line up with State.
    always_comb begin
        iniciar_d = 1'b0;
        whilet_d  = 1'b0;
        crontus_d = '0;
        wdt_err_d = 1'b0;
        case (state_d)
            ST_INIT:      iniciar_d = 1'b1;
            ST_WHILE:     whilet_d  = 1'b1;
            ST_SOLICITUD: iniciar_d = 1'b0;
            ST_CONTROL: begin
                for (int i = 0; i < N_CH; i++) begin
                    crontus_d[i] = (grant_id_d == CH_W'(i));
                end
            end
            ST_ABORT:     wdt_err_d = WDT_ERR_ON;
            default:      iniciar_d = 1'b0;
        endcase
    end

    // Output, grant and pointer registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            iniciar_q  <= 1'b0;
            whilet_q   <= 1'b0;
            crontus_q  <= '0;
            wdt_err_q  <= 1'b0;
        end else begin
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            iniciar_q  <= iniciar_d;
            whilet_q   <= whilet_d;
            crontus_q  <= crontus_d;
            wdt_err_q  <= wdt_err_d;
        end
    end

    assign iniciar  = iniciar_q;
    assign whileT   = whilet_q;
    assign CrontUs  = crontus_q;
    assign grant_id = grant_id_q;
    assign State    = state_q;
    assign wdt_err  = wdt_err_q;

endmodule

// File: doc/rtc_main_ctrl.md
Name: rtc_main_ctrl

Overview:
Parametrised main sequencer for the RTC subsystem.
- Runs one-time RTC initialisation, then loops in a polling ("while true") phase.
- Between polls it services up to N_CH user-request channels with round-robin arbitration, granting one channel at a time.
- Adds a per-phase watchdog that aborts a stuck phase and re-initialises. It sits above the init, poll and user-control sub-FSMs and drives their start/enable lines.

Parameters:
N_CH, 2, number of user request channels (1..8)
TO_CYCLES, 1024, watchdog limit in clock cycles for INIT and CONTROL phases (>=2)
CH_W, max(1,$clog2(N_CH)), width of grant index (derived localparam)
TO_W, $clog2(TO_CYCLES+1), watchdog counter width (derived localparam)

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
finint  in  1  init sub-FSM done
finwt  in  1  poll sub-FSM done
finct  in  1  granted user-control sub-FSM done
usuario  in  N_CH  user request per channel, level
iniciar  out  1  enable init sub-FSM
whileT  out  1  enable poll sub-FSM
CrontUs  out  N_CH  one-hot user-control grant
grant_id  out  CH_W  index of granted channel
State  out  3  current state encoding
wdt_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- States: INIT=3'b000, WHILE=3'b001, SOLICITUD=3'b010, CONTROL=3'b011, ABORT=3'b100. All other codes go to INIT on the next clock.
- Reset (reset=0, async): State=INIT; iniciar=whileT=wdt_err=0; CrontUs=0; grant_id=0; rr_ptr=0; wdt counter=0.
- Output timing: all outputs are registered and decoded from NextState, so from the second cycle after reset release they match State.
- First edge after release: State stays INIT, iniciar goes 1. The one-cycle gap with iniciar=0 is intentional.
- Output decode: INIT gives iniciar=1. WHILE gives whileT=1. CONTROL gives CrontUs=one-hot(grant_id). SOLICITUD gives all enables 0. ABORT gives wdt_err=1 with all enables 0.
- Transitions:
  - INIT: finint goes to WHILE; else stay.
  - WHILE: finwt goes to SOLICITUD; else stay. No timeout.
  - SOLICITUD: any usuario bit goes to CONTROL; else back to WHILE. Lasts exactly one cycle.
  - CONTROL: finct goes to WHILE; else stay.
  - ABORT: unconditionally goes to INIT after one cycle.
- Arbitration:
  - In SOLICITUD, search usuario from rr_ptr upward with wrap. The first set bit becomes grant_id, latched on entry to CONTROL.
  - On CONTROL exit (finct or abort), rr_ptr = (grant_id+1) mod N_CH.
  - usuario is sampled only in SOLICITUD. Deassertion during CONTROL does not drop the grant; new requests wait.
  - N_CH=1: grant_id is always 0.
- Watchdog:
  - Counter clears on every state change and increments each cycle in INIT or CONTROL, saturating.
  - When it reaches TO_CYCLES-1 without the phase's fin input, next state is ABORT.
  - If fin and timeout coincide, fin wins.
- Fin inputs are ignored outside their own state.
- Reset asserted mid-phase returns immediately to reset values. Any in-flight grant is dropped and rr_ptr returns to 0.

Optional Feature:
RTC_CTRL_WDT_EN:
- Defined: watchdog, ABORT state and wdt_err are present as described.
- Undefined: no counter; INIT and CONTROL wait indefinitely; ABORT is unreachable (decodes to INIT); wdt_err is tied 0; TO_CYCLES is unused.

Decomposition:
- Shared package rtc_ctrl_pkg holds the state encodings (INIT..ABORT) as a 3-bit typedef and the default TO_CYCLES constant.
- One natural sub-module: rtc_rr_arbiter (N_CH requests, pointer in, grant index and valid out, combinational), instantiated for the SOLICITUD search.

Test Plan:
- Reset release, finint=1 at cycle 5: iniciar=1 cycles 1-5; State=WHILE and whileT=1 from cycle 6; all outputs 0 during reset.
- N_CH=4, usuario=4'b1010 in SOLICITUD, rr_ptr=0: grant_id=1, CrontUs=4'b0010. After finct and the next SOLICITUD with the same usuario: grant_id=3, CrontUs=4'b1000.
- usuario=0 at SOLICITUD: exactly one cycle in SOLICITUD, then WHILE; CrontUs stays 0.
- WDT_EN, TO_CYCLES=16, finct never asserted: CONTROL for 16 cycles, ABORT one cycle with wdt_err=1, then INIT with iniciar=1; rr_ptr advanced.
- finct and timeout in the same cycle: next State=WHILE, wdt_err stays 0.
- Async reset (reset=0) mid-CONTROL between clock edges: CrontUs=0 and State=INIT immediately; next grant starts from channel 0.
